// File: rtl/kdf_pkg.sv
// Shared definitions for the KDF request controller: FSM state encoding and
// default operand widths.
package kdf_pkg;

  localparam int DEF_N           = 256;
  localparam int DEF_SALT_WIDTH  = 64;
  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_PSW_WIDTH   = 32;
  localparam int DEF_CYC_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } kdf_state_e;

endpackage

// File: rtl/kdf_request_ctrl.sv
// Sequences one key derivation at a time: latches a request, holds the KDF core
// in reset for one launch cycle, counts run cycles and presents the captured key.
module kdf_request_ctrl
  import kdf_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int SALT_WIDTH  = DEF_SALT_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int PSW_WIDTH   = DEF_PSW_WIDTH,
  parameter int CYC_WIDTH   = DEF_CYC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SALT_WIDTH-1:0]  req_salt,
  input  logic [COUNT_WIDTH-1:0] req_count,
  input  logic [PSW_WIDTH-1:0]   req_password,
  input  logic                   abort,
  output logic                   kdf_rst,
  output logic [SALT_WIDTH-1:0]  kdf_salt,
  output logic [COUNT_WIDTH-1:0] kdf_count,
  output logic [PSW_WIDTH-1:0]   kdf_password,
  input  logic                   kdf_end_signal,
  input  logic [N-1:0]           kdf_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [N-1:0]           rsp_key,
  output logic [CYC_WIDTH-1:0]   rsp_cycles,
  output logic                   busy
);

  kdf_state_e state, state_next;

  logic [CYC_WIDTH-1:0] cyc_cnt;
  logic [CYC_WIDTH-1:0] cyc_inc;

  // Saturating increment: a very long derivation pins the count at all-ones.
  assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    kdf_rst    = 1'b1;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = LAUNCH;
      end
      LAUNCH: state_next = RUN;
      RUN: begin
        kdf_rst = 1'b0;
        // Abort wins even when the core finishes in the same cycle.
        if (abort)               state_next = IDLE;
        else if (kdf_end_signal) state_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kdf_salt     <= '0;
      kdf_count    <= '0;
      kdf_password <= '0;
      cyc_cnt      <= '0;
      rsp_key      <= '0;
      rsp_cycles   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            kdf_salt     <= req_salt;
            kdf_count    <= req_count;
            kdf_password <= req_password;
            cyc_cnt      <= '0;
          end
        end
        RUN: begin
          cyc_cnt <= cyc_inc;
          if (abort) begin
            kdf_password <= '0;
          end else if (kdf_end_signal) begin
            rsp_key    <= kdf_key;
            rsp_cycles <= cyc_inc;
          end
        end
        DONE: begin
          // Scrub secrets on handoff; the cycle count stays for diagnostics.
          if (rsp_ready) begin
            rsp_key      <= '0;
            kdf_password <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kdf_request_ctrl.sv
// Randomized self-checking bench for kdf_request_ctrl with a KDF stub that ends
// K run cycles after its reset drops; a second instance checks a 4-bit cycle counter.
module tb_kdf_request_ctrl;

  localparam int N  = 256;
  localparam int SW = 64;
  localparam int CW = 32;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [SW-1:0] req_salt;
  logic [CW-1:0] req_count;
  logic [PW-1:0] req_password;
  logic          abort;
  logic          rsp_ready;
  logic          kdf_end_signal;
  logic [N-1:0]  kdf_key;

  logic          req_ready, kdf_rst, rsp_valid, busy;
  logic [SW-1:0] kdf_salt;
  logic [CW-1:0] kdf_count;
  logic [PW-1:0] kdf_password;
  logic [N-1:0]  rsp_key;
  logic [31:0]   rsp_cycles;

  logic          req_ready_s, kdf_rst_s, rsp_valid_s, busy_s;
  logic [SW-1:0] kdf_salt_s;
  logic [CW-1:0] kdf_count_s;
  logic [PW-1:0] kdf_password_s;
  logic [N-1:0]  rsp_key_s;
  logic [3:0]    rsp_cycles_s;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  kdf_request_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_salt(req_salt), .req_count(req_count), .req_password(req_password),
    .abort(abort), .kdf_rst(kdf_rst),
    .kdf_salt(kdf_salt), .kdf_count(kdf_count), .kdf_password(kdf_password),
    .kdf_end_signal(kdf_end_signal), .kdf_key(kdf_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key), .rsp_cycles(rsp_cycles), .busy(busy)
  );

  kdf_request_ctrl #(.CYC_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_s),
    .req_salt(req_salt), .req_count(req_count), .req_password(req_password),
    .abort(abort), .kdf_rst(kdf_rst_s),
    .kdf_salt(kdf_salt_s), .kdf_count(kdf_count_s), .kdf_password(kdf_password_s),
    .kdf_end_signal(kdf_end_signal), .kdf_key(kdf_key),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_key(rsp_key_s), .rsp_cycles(rsp_cycles_s), .busy(busy_s)
  );

  // KDF stub: counts cycles with its reset low, done level on the K-th such cycle.
  int           stub_k;
  int           stub_cnt;
  logic [N-1:0] stub_key;

  always @(posedge clk) begin
    if (kdf_rst) stub_cnt <= 0;
    else         stub_cnt <= stub_cnt + 1;
  end

  assign kdf_end_signal = !kdf_rst && (stub_cnt + 1 >= stub_k);
  assign kdf_key        = stub_key;

  logic [SW-1:0] nxt_salt;
  logic [CW-1:0] nxt_count;
  logic [PW-1:0] nxt_password;

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [SW-1:0] s,
                               input logic [CW-1:0] c, input logic [PW-1:0] p);
    req_valid    = v;
    req_salt     = s;
    req_count    = c;
    req_password = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reported run cycles: the K cycles the core ran, clipped to the counter range.
  function automatic longint expCycles(input int k, input int width);
    longint lim;
    lim = (64'd1 << width) - 1;
    return (k > lim) ? lim : longint'(k);
  endfunction

  function automatic logic [N-1:0] randKey();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic runRequest(input int k, input logic [N-1:0] key, input int hold,
                            input logic offer_second, input logic [SW-1:0] s,
                            input logic [CW-1:0] c, input logic [PW-1:0] p);
    int   cyc;
    logic done;
    stub_k   = k;
    stub_key = key;
    checkOutput("idle_req_ready", req_ready, 1);
    applyStimulus(1'b1, s, c, p);
    abort = 1'($urandom_range(0, 1));
    step();
    req_valid = 1'b0;
    checkOutput("launch_salt", kdf_salt, s);
    checkOutput("launch_count", kdf_count, c);
    checkOutput("launch_password", kdf_password, p);
    checkOutput("launch_kdf_rst", kdf_rst, 1);
    checkOutput("launch_req_ready", req_ready, 0);
    checkOutput("launch_busy", busy, 1);
    abort = 1'($urandom_range(0, 1));
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < k + 40) begin
      step();
      cyc++;
      if (cyc == 2) abort = 1'b0;
      if (rsp_valid) done = 1'b1;
      else checkOutput("run_kdf_rst", kdf_rst, 0);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL rsp_timeout: observed no rsp_valid after %0d cycles, expected at %0d", cyc, k + 2);
      return;
    end
    checkOutput("rsp_latency", cyc, k + 2);
    checkOutput("rsp_key", rsp_key, key);
    checkOutput("rsp_cycles", rsp_cycles, expCycles(k, 32));
    checkOutput("rsp_cycles_w4", rsp_cycles_s, expCycles(k, 4));
    checkOutput("rsp_valid_w4", rsp_valid_s, 1);
    checkOutput("rsp_key_w4", rsp_key_s, key);
    checkOutput("done_req_ready", req_ready, 0);
    checkOutput("done_kdf_rst", kdf_rst, 1);
    for (int i = 0; i < hold; i++) begin
      if (offer_second) applyStimulus(1'b1, nxt_salt, nxt_count, nxt_password);
      abort = 1'($urandom_range(0, 1));
      step();
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_key", rsp_key, key);
      checkOutput("hold_rsp_cycles", rsp_cycles, expCycles(k, 32));
      checkOutput("hold_req_ready", req_ready, 0);
      checkOutput("hold_salt_kept", kdf_salt, s);
    end
    abort     = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("ack_rsp_valid", rsp_valid, 0);
    checkOutput("ack_rsp_key_zero", rsp_key, 0);
    checkOutput("ack_rsp_cycles_kept", rsp_cycles, expCycles(k, 32));
    checkOutput("ack_password_zero", kdf_password, 0);
    checkOutput("ack_req_ready", req_ready, 1);
    checkOutput("ack_busy", busy, 0);
  endtask

  // Abort lands in run cycle j (1..k); j == k collides with the done level.
  task automatic runAbort(input int k, input int j, input logic [SW-1:0] s,
                          input logic [CW-1:0] c, input logic [PW-1:0] p);
    stub_k   = k;
    stub_key = randKey();
    checkOutput("abort_idle_ready", req_ready, 1);
    applyStimulus(1'b1, s, c, p);
    step();
    req_valid = 1'b0;
    for (int m = 1; m <= j; m++) step();
    checkOutput("abort_run_kdf_rst", kdf_rst, 0);
    checkOutput("abort_run_rsp_valid", rsp_valid, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_kdf_rst", kdf_rst, 1);
    checkOutput("abort_password_zero", kdf_password, 0);
    checkOutput("abort_busy", busy, 0);
    for (int m = 0; m < k + 3; m++) step();
    checkOutput("abort_no_late_rsp", rsp_valid, 0);
  endtask

  task automatic runReset(input int k, input int j);
    stub_k   = k;
    stub_key = randKey();
    applyStimulus(1'b1, {$urandom, $urandom}, $urandom, $urandom);
    step();
    req_valid = 1'b0;
    for (int m = 1; m <= j; m++) step();
    checkOutput("rst_pre_kdf_rst", kdf_rst, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_kdf_rst", kdf_rst, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_key", rsp_key, 0);
    checkOutput("rst_rsp_cycles", rsp_cycles, 0);
    checkOutput("rst_kdf_salt", kdf_salt, 0);
    checkOutput("rst_kdf_count", kdf_count, 0);
    checkOutput("rst_kdf_password", kdf_password, 0);
    checkOutput("rst_w4_cycles", rsp_cycles_s, 0);
    checkOutput("rst_w4_busy", busy_s, 0);
    checkOutput("rst_w4_ready_rst", {req_ready_s, kdf_rst_s}, 2'b11);
    checkOutput("rst_w4_operands", {kdf_salt_s, kdf_count_s, kdf_password_s}, 0);
    for (int m = 0; m < k + 3; m++) step();
    checkOutput("rst_no_late_rsp", rsp_valid, 0);
  endtask

  initial begin
    int kind, k;
    rst       = 1'b1;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    stub_k    = 1;
    stub_key  = '0;
    applyStimulus(1'b0, '0, '0, '0);
    step();
    step();
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_kdf_rst", kdf_rst, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_key", rsp_key, 0);
    checkOutput("reset_rsp_cycles", rsp_cycles, 0);
    checkOutput("reset_operands", {kdf_salt, kdf_count, kdf_password}, 0);
    rst = 1'b0;
    step();

    runRequest(7, {32{8'hA5}}, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 32'd5, 32'hDEAD_BEEF);
    runRequest(1, '0, 0, 1'b0, 64'h1111_2222_3333_4444, 32'd0, 32'hCAFE_F00D);
    runAbort(7, 3, 64'h5555_6666_7777_8888, 32'd5, 32'h1234_5678);

    nxt_salt     = 64'hFEED_FACE_0BAD_F00D;
    nxt_count    = 32'd9;
    nxt_password = 32'h0F0F_0F0F;
    runRequest(4, randKey(), 10, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 32'd3, 32'h8765_4321);
    runRequest(3, randKey(), 0, 1'b0, nxt_salt, nxt_count, nxt_password);

    runRequest(20, randKey(), 1, 1'b0, 64'h9999_0000_9999_0000, 32'd20, 32'h2468_ACE0);
    runReset(7, 4);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 9);
      k    = $urandom_range(1, 25);
      if (kind <= 6)
        runRequest(k, randKey(), $urandom_range(0, 3), 1'b0,
                   {$urandom, $urandom}, $urandom, $urandom);
      else if (kind <= 8)
        runAbort(k, $urandom_range(1, k), {$urandom, $urandom}, $urandom, $urandom);
      else
        runReset(k, $urandom_range(1, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kdf_request_ctrl.md
KDF_REQUEST_CTRL -- requirements
Module: kdf_request_ctrl

Interface
REQ-001 Parameter N, default 256, derived-key width.
REQ-002 Parameter SALT_WIDTH, default 64, salt width.
REQ-003 Parameter COUNT_WIDTH, default 32, iteration-count width.
REQ-004 Parameter PSW_WIDTH, default 32, password width.
REQ-005 Parameter CYC_WIDTH, default 32, run-cycle counter width.
REQ-006 Reset is rst, synchronous, active-high; clock is clk.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  1  request offered.
REQ-010 req_ready  out  1  request accepted when high with req_valid.
REQ-011 req_salt, req_count, req_password  in  SALT_WIDTH, COUNT_WIDTH, PSW_WIDTH  request fields.
REQ-012 abort  in  1  cancel running derivation.
REQ-013 kdf_rst  out  1  reset to the KDF core.
REQ-014 kdf_salt, kdf_count, kdf_password  out  SALT_WIDTH, COUNT_WIDTH, PSW_WIDTH  registered KDF operands.
REQ-015 kdf_end_signal  in  1  KDF done level (iteration counter equals count).
REQ-016 kdf_key  in  N  KDF derived key.
REQ-017 rsp_valid  out  1  result available.
REQ-018 rsp_ready  in  1  consumer accepts result.
REQ-019 rsp_key  out  N  captured derived key.
REQ-020 rsp_cycles  out  CYC_WIDTH  RUN cycles spent on the derivation.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, LAUNCH, RUN, DONE; all outputs registered or decoded from state only.
REQ-023 IDLE: req_ready=1, kdf_rst=1; on req_valid&req_ready latch all three fields into kdf_* registers, clear cycle counter, go LAUNCH.
REQ-024 LAUNCH: exactly one cycle, kdf_rst=1 with new operands stable, kdf_end_signal ignored; go RUN.
REQ-025 RUN: kdf_rst=0; cycle counter increments by 1 per cycle, saturating at all-ones, no wrap.
REQ-026 RUN with kdf_end_signal=1: capture kdf_key into rsp_key and counter (including this cycle) into rsp_cycles; go DONE.
REQ-027 req_count=0: end_signal high on first RUN cycle; key captured is KDF register value (zero); rsp_valid high 3 cycles after acceptance, rsp_cycles=1.
REQ-028 RUN with abort=1: go IDLE, no response, zero kdf_password; abort has priority over simultaneous kdf_end_signal.
REQ-029 abort outside RUN has no effect.
REQ-030 DONE: rsp_valid=1, kdf_rst=1; rsp_key and rsp_cycles stable while rsp_valid; req_ready=0.
REQ-031 DONE with rsp_ready=1: go IDLE, zero rsp_key and kdf_password in the same edge; rsp_cycles retained.
REQ-032 req_ready=0 in LAUNCH, RUN, DONE; requests there are not accepted and must be held by the producer.
REQ-033 Back-to-back: request offered in IDLE cycle after a DONE handshake is accepted immediately.

Reset
REQ-034 rst returns FSM to IDLE from any state, including mid-RUN, within one edge.
REQ-035 Reset values: req_ready=1, kdf_rst=1, rsp_valid=0, busy=0, rsp_key=0, rsp_cycles=0, kdf_salt/kdf_count/kdf_password=0, cycle counter=0.

Structure
REQ-036 Shared package kdf_pkg holds the state enum and default width constants (N, SALT_WIDTH, COUNT_WIDTH, PSW_WIDTH, CYC_WIDTH).
REQ-037 No sub-module; single FSM plus registers; KDF core instantiated by the parent, not inside this block.

Verification
REQ-038 Bench uses a KDF stub asserting kdf_end_signal K cycles after kdf_rst falls and driving kdf_key=constant.
REQ-039 Request count=5, stub K=7, key=0xA5..A5 -> rsp_valid 9 cycles after acceptance, rsp_key=0xA5..A5, rsp_cycles=7.
REQ-040 Request count=0 -> rsp_valid 3 cycles after acceptance, rsp_key=0, rsp_cycles=1.
REQ-041 abort in 3rd RUN cycle, K=7 -> no rsp_valid, back in IDLE next cycle, kdf_password=0, kdf_rst=1.
REQ-042 rsp_ready held low 10 cycles in DONE -> rsp_key/rsp_cycles constant, req_ready=0, second request not accepted; rsp_ready high -> rsp_key=0 next cycle, second request accepted following cycle.
REQ-043 CYC_WIDTH=4, K=20 -> rsp_cycles=15 (saturated).
REQ-044 rst asserted mid-RUN -> all REQ-035 values next cycle; no rsp_valid.
